// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared types, default palette encoding and helpers for the VGA mixer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int DEF_COLOR_W = 4;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  // Default palette as channel-saturation masks {r,g,b}; each set bit means max.
  localparam logic [2:0] DEF_PAL_L0 = 3'b100;
  localparam logic [2:0] DEF_PAL_L1 = 3'b010;
  localparam logic [2:0] DEF_PAL_L2 = 3'b001;
  localparam logic [2:0] DEF_PAL_LX = 3'b111;
  localparam logic [2:0] DEF_PAL_BG = 3'b000;

  function automatic int BG_IDX(input int num_layers);
    return num_layers;
  endfunction

  function automatic logic [2:0] def_pal_mask(input int idx, input int num_layers);
    if (idx == num_layers) return DEF_PAL_BG;
    case (idx)
      0:       return DEF_PAL_L0;
      1:       return DEF_PAL_L1;
      2:       return DEF_PAL_L2;
      default: return DEF_PAL_LX;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_prio_enc.sv
// ============================================================================
// Module  : vga_prio_enc
// Brief   : Lowest-set-bit priority encoder with an explicit none flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          none_o
);

  // Scanning downward lets the lowest set bit overwrite all higher ones.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o  = IW'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_layer_mixer.sv
// ============================================================================
// Module  : vga_layer_mixer
// Brief   : Priority layer compositor with frame-synchronous palette, collision
//           reporting and sync delay. Optional blink: VGA_LAYER_MIXER_BLINK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_layer_mixer
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int IDX_W      = 3,
`ifdef VGA_LAYER_MIXER_BLINK_EN
  localparam int PAL_W     = 3 * COLOR_W + 1
`else
  localparam int PAL_W     = 3 * COLOR_W
`endif
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic                  disparea,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic [NUM_LAYERS-1:0] layer_hit,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [PAL_W-1:0]      cfg_data,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic [COLOR_W-1:0]    vga_r,
  output logic [COLOR_W-1:0]    vga_g,
  output logic [COLOR_W-1:0]    vga_b,
  output logic                  frame_start,
  output logic [NUM_LAYERS-1:0] collide_mask
);

  localparam int RGB_W = 3 * COLOR_W;
  localparam int BG    = BG_IDX(NUM_LAYERS);

  typedef logic [PAL_W-1:0] pal_t;

  function automatic pal_t default_entry(input int idx);
    logic [2:0] m;
    pal_t       e;
    m = def_pal_mask(idx, NUM_LAYERS);
    e = '0;
    e[RGB_W-1:0] = {{COLOR_W{m[2]}}, {COLOR_W{m[1]}}, {COLOR_W{m[0]}}};
    return e;
  endfunction

  pal_t                  shadow_q [NUM_LAYERS+1];
  pal_t                  shadow_d [NUM_LAYERS+1];
  pal_t                  active_q [NUM_LAYERS+1];
  pal_t                  active_d [NUM_LAYERS+1];
  logic                  vs_prev_q;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic                  de1_q, hs1_q, vs1_q;
  logic [RGB_W-1:0]      rgb_q, rgb_d;
  logic                  hs_q, vs_q;
  logic [NUM_LAYERS-1:0] acc_q, acc_d;
  logic [NUM_LAYERS-1:0] collide_q, collide_d;

  logic                  w_frame_start;
  logic [NUM_LAYERS-1:0] w_vis;
  logic [NUM_LAYERS-1:0] w_hits;
  logic                  w_multi;
  logic [IDX_W-1:0]      w_enc_idx;
  logic                  w_enc_none;

  // Gated by reset_n so the pulse stays low while the block is held in reset.
  assign w_frame_start = reset_n & vs_prev_q & ~vs_in;

`ifdef VGA_LAYER_MIXER_BLINK_EN
  logic [5:0]            frame_cnt_q, frame_cnt_d;
  logic [NUM_LAYERS-1:0] w_blink;

  always_comb begin
    w_blink = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_blink[i] = active_q[i][PAL_W-1];
    end
  end

  assign frame_cnt_d = w_frame_start ? frame_cnt_q + 6'd1 : frame_cnt_q;
  assign w_vis = layer_hit & {NUM_LAYERS{disparea}} & ~(w_blink & {NUM_LAYERS{frame_cnt_q[5]}});

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= 6'd0;
    else          frame_cnt_q <= frame_cnt_d;
  end
`else
  assign w_vis = layer_hit & {NUM_LAYERS{disparea}};
`endif

  vga_prio_enc #(
    .N  (NUM_LAYERS),
    .IW (IDX_W)
  ) u_prio_enc (
    .req_i  (w_vis),
    .idx_o  (w_enc_idx),
    .none_o (w_enc_none)
  );

  assign sel_d = w_enc_none ? IDX_W'(BG) : w_enc_idx;

  // Collision uses the raw hits, so blink-masked layers still register overlap.
  generate
    if (NUM_LAYERS == 1) begin : g_single
      assign w_multi = 1'b0;
    end else begin : g_multi
      assign w_multi = disparea && ((layer_hit & (layer_hit - NUM_LAYERS'(1))) != '0);
    end
  endgenerate

  assign w_hits    = w_multi ? layer_hit : '0;
  assign acc_d     = w_frame_start ? '0 : (acc_q | w_hits);
  assign collide_d = w_frame_start ? (acc_q | w_hits) : collide_q;

  // The active copy takes the pre-edge shadow, so a same-cycle write waits a frame.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (w_frame_start) active_d = shadow_q;
    if (cfg_we && (cfg_addr <= IDX_W'(BG))) shadow_d[cfg_addr] = cfg_data;
  end

  assign rgb_d = de1_q ? active_q[sel_q][RGB_W-1:0] : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NUM_LAYERS; i++) begin
        shadow_q[i] <= default_entry(i);
        active_q[i] <= default_entry(i);
      end
      vs_prev_q <= 1'b1;
      sel_q     <= '0;
      de1_q     <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      acc_q     <= '0;
      collide_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      vs_prev_q <= vs_in;
      sel_q     <= sel_d;
      de1_q     <= disparea;
      hs1_q     <= hs_in;
      vs1_q     <= vs_in;
      rgb_q     <= rgb_d;
      hs_q      <= hs1_q;
      vs_q      <= vs1_q;
      acc_q     <= acc_d;
      collide_q <= collide_d;
    end
  end

  assign vga_r        = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g        = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b        = rgb_q[COLOR_W-1:0];
  assign hs_out       = hs_q;
  assign vs_out       = vs_q;
  assign frame_start  = w_frame_start;
  assign collide_mask = collide_q;

endmodule

`default_nettype wire
